// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle.
// Carries the instruction-memory request/ack channel, the branch redirect
// inputs and the valid/ready output handshake toward decode.
//   master : instruction fetch stage (drives imem_req/imem_addr and the decode outputs)
//   slave  : environment (memory, branch unit, decode)
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        id_ready;
    logic [31:0] instrucao;
    logic [31:0] pc_out;

    modport master (
        output imem_req, imem_addr, instr_valid, instrucao, pc_out,
        input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instrucao, pc_out,
        output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Holds the PC, keeps at most one instruction-memory request outstanding and
// presents {instrucao, pc_out} to decode through a valid/ready handshake.
// A redirect flushes the output slot and discards any fetch still in flight.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : instr_fetch_if.master (imem req/addr/ack/rdata, redirect,
//                 redirect_pc, instr_valid, id_ready, instrucao, pc_out)
//
// state | meaning
// IDLE  | no request outstanding; imem_addr shows pc
// WAIT  | request outstanding, its data will be captured
// KILL  | request outstanding, its data will be dropped (redirected meanwhile)
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, KILL = 2'd2} state_t;

    localparam logic [31:0] RESET_PC_W = RESET_PC & ~32'd3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pco_q, pco_d;
    logic        valid_q, valid_d;
    logic        slot_free, transfer, issue, capture;
    logic [31:0] fetch_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC_W;
            addr_q  <= 32'd0;
            instr_q <= 32'd0;
            pco_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            pco_q   <= pco_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        slot_free  = ~valid_q | bus.id_ready;
        transfer   = valid_q & bus.id_ready;
        // A new fetch only starts when its result is guaranteed a free slot,
        // so an ack can never overwrite an instruction decode has not taken.
        issue      = (state_q == IDLE) & slot_free & ~bus.redirect;
        fetch_addr = (state_q == IDLE) ? pc_q : addr_q;

        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        capture = 1'b0;

        case (state_q)
            IDLE: begin
                if (issue) begin
                    addr_d = pc_q;
                    if (bus.imem_ack) capture = 1'b1;
                    else              state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_ack) begin
                    state_d = IDLE;
                    capture = ~bus.redirect;
                end else if (bus.redirect) begin
                    state_d = KILL;
                end
            end
            KILL: begin
                if (bus.imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.redirect)  pc_d = bus.redirect_pc & ~32'd3;
        else if (capture)  pc_d = fetch_addr + 32'd4;

        instr_d = capture ? bus.imem_rdata : instr_q;
        pco_d   = capture ? fetch_addr     : pco_q;

        if (bus.redirect)     valid_d = 1'b0;
        else if (capture)     valid_d = 1'b1;
        else if (transfer)    valid_d = 1'b0;
        else                  valid_d = valid_q;
    end

    // Gating with rst_n keeps the request low while reset is held, even though
    // IDLE with an empty slot would otherwise request combinationally.
    assign bus.imem_req    = rst_n & (issue | (state_q != IDLE));
    assign bus.imem_addr   = fetch_addr;
    assign bus.instr_valid = valid_q;
    assign bus.instrucao   = instr_q;
    assign bus.pc_out      = pco_q;
endmodule
